pipe_add_sub: RTL and testbench
===============================

Name: pipe_add_sub

Overview:
- Parametrised, pipelined successor to the team's 8-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands. The carry chain is split into SEG ripple segments, one register stage per segment; operand and result slices are skewed so one operation is accepted per cycle.
- Valid/ready handshake on both sides; full-stall backpressure.
- Sits in the datapath as the general-purpose integer adder/subtractor.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SEG, minimum 2.
- SEG, 4, number of ripple segments = pipeline stages = latency in cycles; 1 <= SEG <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (borrow-in when sub=1).
- sub  input  1  0: a+b+cin; 1: a+~b+(cin^1), i.e. a-b-cin.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of MSB; for sub, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (async assert, sync deassert by caller): every stage valid = 0; sum = 0, cout = 0, ovf = 0, out_valid = 0. in_ready = 1 once reset is released.
- Effective B slice: b ^ {WIDTH{sub}}. Effective carry-in: cin ^ sub.
- Stage k (0..SEG-1) computes bits [k*W/SEG +: W/SEG] via ripple full adders, using the carry registered by stage k-1 (stage 0 uses the effective carry-in).
- Stage k holds the computed low slices plus the not-yet-added upper operand slices (skew registers) and the sub flag.
- Advance rule: adv = !out_valid || out_ready. All stages shift together when adv = 1 and hold when adv = 0. in_ready = adv (combinational).
- Transfer on in_valid && in_ready. Bubbles (in_valid = 0) propagate as valid = 0; no bubble collapse.
- Latency: an op accepted in cycle N presents out_valid = 1 in cycle N+SEG, provided adv stayed 1. Throughput is 1 op/cycle.
- sum/cout/ovf are registered, stable, and held while out_valid && !out_ready.
- ovf = (a[MSB] == beff[MSB]) && (sum[MSB] != a[MSB]), computed from the raw sum before any saturation.
- Outputs of an invalid slot are don't-care, except that they remain at their last value (no toggling on bubbles).
- SEG = 1 degenerates to a single registered adder with latency 1.
- Reset mid-operation: all in-flight ops are discarded; no result emerges after rst_n deasserts.
- Simultaneous out_ready drop and in_valid: in_ready falls in the same cycle and the op is not accepted.

Optional Feature:
- Macro: PIPE_ADD_SAT_EN.
- Defined: when ovf = 1, sum is clamped to signed max (0111..1) if a[MSB] = 0, else signed min (1000..0). ovf still reports 1; cout is unchanged.
- Undefined: sum is the wrapped modular result and no clamp logic is instantiated.

Test Plan (WIDTH=16, SEG=4):
- Reset/idle: rst_n = 0 -> out_valid = 0, sum = 0x0000, in_ready = 1. Release reset, hold in_valid = 0 for 10 cycles -> out_valid stays 0.
- Add with full carry ripple: a = 0xFFFF, b = 0x0001, cin = 0, sub = 0, accepted cycle N -> cycle N+4: sum = 0x0000, cout = 1, ovf = 0.
- Subtract and borrow: a = 0x0005, b = 0x0007, sub = 1, cin = 0 -> sum = 0xFFFE, cout = 0. Same with cin = 1 -> sum = 0xFFFD.
- Signed overflow: a = 0x7FFF, b = 0x0001, add -> ovf = 1, sum = 0x8000 (sum = 0x7FFF with PIPE_ADD_SAT_EN). Also a = 0x8000, b = 0x0001, sub -> ovf = 1.
- Backpressure:
  - Stream 8 back-to-back random ops and hold out_ready = 0 for 3 cycles mid-stream -> in_ready = 0 during the stall, outputs held.
  - All 8 results arrive in order and match the reference model.
  - No op is lost or duplicated.
- Reset mid-flight: accept 3 ops, assert rst_n = 0 for 1 cycle -> out_valid = 0 immediately, and no stale result appears over the next 6 cycles.

Source files
------------

// File: rtl/pipe_add_sub.sv
// pipe_add_sub: pipelined WIDTH-bit adder/subtractor.
//
// The carry chain is cut into SEG ripple segments with one register stage
// per segment. Each stage adds one W/SEG-bit slice using the carry left by
// the previous stage, and carries the finished low slices plus the
// still-unadded upper operand slices forward (skewed operands). Latency is
// SEG cycles and one op is accepted per cycle.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready = pipeline can advance)
//   a, b, cin, sub       operands; sub=1 computes a - b - cin
//   out_valid/out_ready  result handshake, full stall on backpressure
//   sum, cout, ovf       registered result, carry-out (sub: 1 = no borrow),
//                        two's-complement overflow
//
// Build option: define PIPE_ADD_SAT_EN to clamp sum to the signed max/min
// on overflow (ovf and cout are unaffected).

module pipe_add_sub_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module pipe_add_sub #(
    parameter int WIDTH = 16,   // multiple of SEG, >= 2
    parameter int SEG   = 4     // 1..WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SW  = WIDTH / SEG;
    localparam int MSB = WIDTH - 1;

    logic           adv;
    logic [SEG:1]   vld_pipe;   // vld_pipe[k]: slot entering stage k (k=SEG: output)

    // Whole pipe moves as one; a held result freezes everything behind it.
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[SEG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else if (adv) begin
            for (int i = SEG; i > 1; i--) vld_pipe[i] <= vld_pipe[i-1];
            vld_pipe[1] <= in_valid;
        end
    end

    // The sub flag is folded into the effective B and carry-in at entry, so
    // no stage needs to carry it further.
    for (genvar k = 0; k < SEG; k++) begin : stg
        localparam int LO = k * SW;
        localparam int YW = WIDTH - LO;

        logic [WIDTH-1:0] x_in;   // [LO-1:0] finished sum, [MSB:LO] operand A
        logic [YW-1:0]    y_in;   // effective B bits not yet added
        logic             c_in;
        logic             v_in;
        logic [SW:0]      cc;
        logic [SW-1:0]    s_seg;
        logic [WIDTH-1:0] x_nx;
        logic             ld;

        if (k == 0) begin : g_src
            assign x_in = a;
            assign y_in = b ^ {WIDTH{sub}};
            assign c_in = cin ^ sub;
            assign v_in = in_valid;
        end else begin : g_src
            assign x_in = stg[k-1].g_reg.x_q;
            assign y_in = stg[k-1].g_reg.y_q;
            assign c_in = stg[k-1].g_reg.c_q;
            assign v_in = vld_pipe[k];
        end

        assign cc[0] = c_in;
        for (genvar i = 0; i < SW; i++) begin : g_fa
            pipe_add_sub_fa u_fa (
                .a  (x_in[LO+i]),
                .b  (y_in[i]),
                .ci (cc[i]),
                .s  (s_seg[i]),
                .co (cc[i+1])
            );
        end

        always_comb begin
            x_nx           = x_in;
            x_nx[LO +: SW] = s_seg;
        end

        // Only load real ops so bubbles never disturb held values.
        assign ld = adv && v_in;

        if (k < SEG-1) begin : g_reg
            logic [WIDTH-1:0]  x_q;
            logic [YW-SW-1:0]  y_q;
            logic              c_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    x_q <= '0;
                    y_q <= '0;
                    c_q <= 1'b0;
                end else if (ld) begin
                    x_q <= x_nx;
                    y_q <= y_in[YW-1:SW];
                    c_q <= cc[SW];
                end
            end
        end else begin : g_last
            logic [WIDTH-1:0] res;
            logic             v_ovf;

            // Same-sign operands producing an opposite-sign raw sum.
            assign v_ovf = (x_in[MSB] == y_in[YW-1]) && (x_nx[MSB] != x_in[MSB]);

`ifdef PIPE_ADD_SAT_EN
            always_comb begin
                res = x_nx;
                if (v_ovf) res = x_in[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
            end
`else
            assign res = x_nx;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum  <= '0;
                    cout <= 1'b0;
                    ovf  <= 1'b0;
                end else if (ld) begin
                    sum  <= res;
                    cout <= cc[SW];
                    ovf  <= v_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipe_add_sub.sv
module tb_pipe_add_sub;
    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready;
    logic [W-1:0] a, b, sum;
    logic         cin, sub;
    logic         out_valid, out_ready;
    logic         cout, ovf;

    always #5 clk = ~clk;

    pipe_add_sub #(.WIDTH(W), .SEG(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    typedef struct {
        logic [W+1:0] res;   // {ovf, cout, sum}
        int           acc;   // cycle of acceptance
    } exp_t;

    exp_t         q[$];
    int           vec = 0, miss = 0, cyc = 0, pops = 0;
    bit           lat_chk = 1'b0;
    logic [W+1:0] prev_out = '0, last_res = '0, held = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on the operand values.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic sb);
        int           sx, sy, r, ux, uy;
        logic         o, co;
        logic [W-1:0] s;
        sx = int'($signed(x));
        sy = int'($signed(y));
        ux = int'(x);
        uy = int'(y);
        if (sb) begin
            r  = sx - sy - int'(ci);
            co = (ux >= uy + int'(ci));
        end else begin
            r  = sx + sy + int'(ci);
            co = (ux + uy + int'(ci)) >= 65536;
        end
        o = (r > 32767) || (r < -32768);
        s = r[W-1:0];
`ifdef PIPE_ADD_SAT_EN
        if (o) s = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {o, co, s};
    endfunction

    // One clock: score the output handshake and the input handshake seen
    // just before the edge, then advance past the edge.
    task automatic cycle();
        logic [W+1:0] cur;
        exp_t         e;
        #1;
        cur = {ovf, cout, sum};
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                e = q.pop_front();
                chk("result", cur, e.res);
                if (lat_chk) chk("latency", cyc - e.acc, S);
                last_res = cur;
                pops++;
            end
        end else if (!out_valid) begin
            chk("bubble_hold", cur, prev_out);
        end
        prev_out = cur;
        if (in_valid && in_ready) q.push_back('{model(a, b, cin, sub), cyc});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && n < 50) begin
            cycle();
            n++;
        end
        chk("drained", q.size(), 0);
    endtask

    task automatic new_ops();
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    initial begin
        int   acc, p0;
        logic now_acc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", {ovf, cout, sum}, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_out = '0;
        repeat (10) begin
            chk("idle_valid", out_valid, 0);
            cycle();
        end

        // Directed corner cases, one op at a time, latency checked.
        lat_chk = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0); drain();
        chk("ffff_plus_1", last_res, {1'b0, 1'b1, 16'h0000});
        send(16'h0005, 16'h0007, 1'b0, 1'b1); drain();
        chk("5_minus_7", last_res, {1'b0, 1'b0, 16'hFFFE});
        send(16'h0005, 16'h0007, 1'b1, 1'b1); drain();
        chk("5_minus_7_borrow", last_res, {1'b0, 1'b0, 16'hFFFD});
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0); drain();
`ifdef PIPE_ADD_SAT_EN
        chk("7fff_plus_1", last_res, {1'b1, 1'b0, 16'h7FFF});
`else
        chk("7fff_plus_1", last_res, {1'b1, 1'b0, 16'h8000});
`endif
        send(16'h8000, 16'h0001, 1'b0, 1'b1); drain();
`ifdef PIPE_ADD_SAT_EN
        chk("8000_minus_1", last_res, {1'b1, 1'b1, 16'h8000});
`else
        chk("8000_minus_1", last_res, {1'b1, 1'b1, 16'h7FFF});
`endif
        lat_chk = 1'b0;

        // 8 back-to-back ops with a 3-cycle output stall mid-stream.
        acc = 0; p0 = pops;
        new_ops();
        for (int t = 0; t < 60 && (acc < 8 || q.size() != 0); t++) begin
            out_ready = !(t >= 5 && t <= 7);
            in_valid  = (acc < 8);
            #1;
            if (t == 5) held = {ovf, cout, sum};
            if (t >= 5 && t <= 7) begin
                chk("stall_in_ready", in_ready, 0);
                chk("stall_out_valid", out_valid, 1);
            end
            if (t == 6 || t == 7) chk("stall_hold", {ovf, cout, sum}, held);
            now_acc = in_valid && in_ready;
            cycle();
            if (now_acc) begin
                acc++;
                new_ops();
            end
        end
        chk("stream_count", pops - p0, 8);
        chk("stream_drained", q.size(), 0);

        // Random traffic with random gaps and random backpressure.
        acc = 0; p0 = pops;
        new_ops();
        for (int t = 0; t < 600 && (acc < 40 || q.size() != 0); t++) begin
            in_valid  = (acc < 40) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            now_acc = in_valid && in_ready;
            cycle();
            if (now_acc) begin
                acc++;
                new_ops();
            end
        end
        chk("rand_count", pops - p0, 40);
        chk("rand_drained", q.size(), 0);

        // Reset while ops are in flight and one result is being held.
        out_ready = 1'b1;
        repeat (3) begin
            new_ops();
            in_valid = 1'b1;
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cycle();
        #1;
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_outputs", {ovf, cout, sum}, 0);
        chk("midrst_in_ready", in_ready, 1);
        q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        prev_out  = '0;
        repeat (6) begin
            chk("post_rst_valid", out_valid, 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end
endmodule
